// File: rtl/round_off.sv
// rtl/round_off.sv - posit(32,3) rounding stage: round-to-nearest-even with exponent/regime carry
module round_off (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] shifted_mantissa,
  input  logic [5:0]  k_out,
  input  logic [2:0]  exp_out,
  input  logic        sign_out,
  output logic [31:0] mantissa_out,
  output logic [5:0]  k_final,
  output logic [2:0]  exp_final,
  output logic        sign_final,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ROUND    = 2'd1,
    S_COMPLETE = 2'd2
  } state_t;

  state_t      r_state;

  // Operands captured in IDLE; the datapath only ever looks at these copies.
  logic [63:0] r_sm;
  logic [5:0]  r_k;
  logic [2:0]  r_exp;
  logic        r_sign;

  // Registered results, held until the next ROUND.
  logic [31:0] r_mant;
  logic [5:0]  r_kf;
  logic [2:0]  r_ef;
  logic        r_sf;
  logic        r_done;

  logic [6:0]  w_rl;
  logic [4:0]  w_fw;
  logic [5:0]  w_gidx;
  logic [5:0]  w_lidx;
  logic        w_guard;
  logic        w_sticky;
  logic        w_lsb;
  logic        w_round_up;
  logic [31:0] w_keep_mask;
  logic [31:0] w_kept;
  logic [32:0] w_inc;
  logic [32:0] w_sum;
  logic [31:0] w_mant_n;
  logic [5:0]  w_k_n;
  logic [2:0]  w_e_n;

  // Regime run length and the fraction width left over in a 32-bit posit.
  always_comb begin
    w_rl = 7'd0;
    w_fw = 5'd0;
    if (r_k[5]) begin
      // -k, computed in 7 bits so k = -32 yields +32 without overflow
      w_rl = (7'd0 - {r_k[5], r_k}) + 7'd1;
    end else begin
      w_rl = {1'b0, r_k} + 7'd2;
    end
    if (w_rl < 7'd28) begin
      w_fw = 5'd28 - w_rl[4:0];
    end
  end

  // Rounding fields. The kept fraction is handled MSB-aligned in a 32-bit word,
  // so a rounding increment is a 1 at bit (32 - fw); bit 32 of the sum is the
  // fraction overflow. With fw = 0 the kept word is empty and the increment is
  // exactly bit 32, so that case falls out as an overflow automatically.
  always_comb begin
    w_gidx      = 6'd63 - {1'b0, w_fw};
    w_lidx      = w_gidx + 6'd1;
    w_guard     = r_sm[w_gidx];
    w_sticky    = |(r_sm & ((64'd1 << w_gidx) - 64'd1));
    w_lsb       = (w_fw == 5'd0) ? r_exp[0] : r_sm[w_lidx];
    w_round_up  = w_guard & (w_sticky | w_lsb);
    w_keep_mask = ~(32'hFFFF_FFFF >> w_fw);
    w_kept      = r_sm[63:32] & w_keep_mask;
    w_inc       = 33'd1 << (6'd32 - {1'b0, w_fw});
    w_sum       = {1'b0, w_kept} + w_inc;
  end

  // Apply the round-up and ripple any fraction overflow into exponent then regime.
  always_comb begin
    w_mant_n = w_kept;
    w_k_n    = r_k;
    w_e_n    = r_exp;
    if (w_round_up) begin
      if (w_sum[32]) begin
        w_mant_n = 32'd0;
        if (r_exp == 3'd7) begin
          if (r_k == 6'd31) begin
            // Largest regime already: saturate instead of wrapping to k = -32.
            w_k_n = 6'd31;
            w_e_n = 3'd7;
          end else begin
            w_k_n = r_k + 6'd1;
            w_e_n = 3'd0;
          end
        end else begin
          w_e_n = r_exp + 3'd1;
        end
      end else begin
        w_mant_n = w_sum[31:0];
      end
    end
  end

  // Control FSM with registered outputs; done is set on entry to COMPLETE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sm    <= 64'd0;
      r_k     <= 6'd0;
      r_exp   <= 3'd0;
      r_sign  <= 1'b0;
      r_mant  <= 32'd0;
      r_kf    <= 6'd0;
      r_ef    <= 3'd0;
      r_sf    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sm    <= shifted_mantissa;
            r_k     <= k_out;
            r_exp   <= exp_out;
            r_sign  <= sign_out;
            r_state <= S_ROUND;
          end
        end
        S_ROUND: begin
          r_mant  <= w_mant_n;
          r_kf    <= w_k_n;
          r_ef    <= w_e_n;
          r_sf    <= r_sign;
          r_done  <= 1'b1;
          r_state <= S_COMPLETE;
        end
        S_COMPLETE: begin
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mantissa_out = r_mant;
  assign k_final      = r_kf;
  assign exp_final    = r_ef;
  assign sign_final   = r_sf;
  assign done         = r_done;

endmodule

// File: tb/tb_round_off.sv
// tb/tb_round_off.sv - scoreboard bench for round_off with a reference model
module tb_round_off;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] shifted_mantissa;
  logic [5:0]  k_out;
  logic [2:0]  exp_out;
  logic        sign_out;
  logic [31:0] mantissa_out;
  logic [5:0]  k_final;
  logic [2:0]  exp_final;
  logic        sign_final;
  logic        done;

  typedef struct {
    logic [31:0] m;
    logic [5:0]  k;
    logic [2:0]  e;
    logic        s;
  } result_t;

  result_t exp_q[$];
  int      n_vec = 0;
  int      n_err = 0;
  logic    prev_done = 1'b0;

  round_off dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .shifted_mantissa (shifted_mantissa),
    .k_out            (k_out),
    .exp_out          (exp_out),
    .sign_out         (sign_out),
    .mantissa_out     (mantissa_out),
    .k_final          (k_final),
    .exp_final        (exp_final),
    .sign_final       (sign_final),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: arithmetic on integers straight from the rounding rules.
  function automatic result_t model(input logic [5:0] k, input logic [2:0] e,
                                    input logic s, input logic [63:0] sm);
    result_t r;
    int kv = int'($signed(k));
    int ev = int'(e);
    int rl = (kv >= 0) ? kv + 2 : -kv + 1;
    int fw = (rl < 28) ? 28 - rl : 0;
    longint unsigned kept = (fw == 0) ? 64'd0 : (sm >> (64 - fw));
    bit guard  = sm[63 - fw];
    bit sticky = ((sm << (fw + 1)) != 64'd0);
    bit lsb    = (fw == 0) ? e[0] : kept[0];
    if (guard && (sticky || lsb)) begin
      kept = kept + 1;
      if (kept == (64'd1 << fw)) begin
        kept = 0;
        ev = ev + 1;
        if (ev == 8) begin
          ev = 0;
          kv = kv + 1;
          if (kv == 32) begin
            kv = 31;
            ev = 7;
          end
        end
      end
    end
    r.m = (fw == 0) ? 32'd0 : 32'(kept << (32 - fw));
    r.k = 6'(kv);
    r.e = 3'(ev);
    r.s = s;
    return r;
  endfunction

  // Monitor: on each rising done, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (rst_n && done && !prev_done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got result with empty scoreboard, expected none");
      end else begin
        result_t x;
        x = exp_q.pop_front();
        chk("mantissa_out", {32'd0, mantissa_out}, {32'd0, x.m});
        chk("k_final", {58'd0, k_final}, {58'd0, x.k});
        chk("exp_final", {61'd0, exp_final}, {61'd0, x.e});
        chk("sign_final", {63'd0, sign_final}, {63'd0, x.s});
      end
    end
    prev_done <= done;
  end

  // One full handshake: issue, check 2-cycle latency, hold start, release.
  task automatic run_op(input logic [5:0] k, input logic [2:0] e, input logic s,
                        input logic [63:0] sm, input result_t req);
    int cyc;
    int hold;
    @(negedge clk);
    k_out = k;
    exp_out = e;
    sign_out = s;
    shifted_mantissa = sm;
    start = 1'b1;
    exp_q.push_back(req);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        // operands are latched; these must be ignored
        shifted_mantissa = {$urandom, $urandom};
        k_out = 6'($urandom);
        exp_out = 3'($urandom);
        sign_out = ~s;
      end
    end while (!done && cyc < 10);
    chk("latency", 64'(cyc), 64'd2);
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk);
      chk("done_hold", {63'd0, done}, 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("done_fall", {63'd0, done}, 64'd0);
  endtask

  task automatic run_model(input logic [5:0] k, input logic [2:0] e, input logic s,
                           input logic [63:0] sm);
    run_op(k, e, s, sm, model(k, e, s, sm));
  endtask

  function automatic result_t mk(input logic [31:0] m, input logic [5:0] k,
                                 input logic [2:0] e, input logic s);
    result_t r;
    r.m = m; r.k = k; r.e = e; r.s = s;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0;
    shifted_mantissa = 64'd0;
    k_out = 6'd0;
    exp_out = 3'd0;
    sign_out = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mantissa", {32'd0, mantissa_out}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_k", {58'd0, k_final}, 64'd0);
    chk("idle_exp", {61'd0, exp_final}, 64'd0);
    chk("idle_sign", {63'd0, sign_final}, 64'd0);

    // Directed vectors with hand-derived results.
    run_op(6'd5,  3'd4, 1'b0, 64'hAAAAAAAA_FFFFFFFF, mk(32'hAAAAA800, 6'd5, 3'd4, 1'b0));
    run_op(6'd2,  3'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, mk(32'h00000000, 6'd2, 3'd1, 1'b0));
    run_op(6'd0,  3'd0, 1'b0, 64'h00000020_00000000, mk(32'h00000000, 6'd0, 3'd0, 1'b0));
    run_op(6'd0,  3'd0, 1'b0, 64'h00000060_00000000, mk(32'h00000080, 6'd0, 3'd0, 1'b0));
    run_op(6'd26, 3'd3, 1'b0, 64'h80000000_00000001, mk(32'h00000000, 6'd26, 3'd4, 1'b0));
    run_op(6'd26, 3'd2, 1'b0, 64'h80000000_00000000, mk(32'h00000000, 6'd26, 3'd2, 1'b0));
    run_op(6'd26, 3'd3, 1'b0, 64'h80000000_00000000, mk(32'h00000000, 6'd26, 3'd4, 1'b0));
    run_op(6'h21, 3'd7, 1'b0, 64'hFFFFFFFF_00000000, mk(32'h00000000, 6'h22, 3'd0, 1'b0));
    run_op(6'd31, 3'd7, 1'b0, 64'hFFFFFFFF_FFFFFFFF, mk(32'h00000000, 6'd31, 3'd7, 1'b0));

    // Reset while in ROUND aborts the operation and clears outputs at once.
    @(negedge clk);
    k_out = 6'd3;
    exp_out = 3'd5;
    sign_out = 1'b1;
    shifted_mantissa = 64'hDEADBEEF_12345678;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_mantissa", {32'd0, mantissa_out}, 64'd0);
    chk("abort_k", {58'd0, k_final}, 64'd0);
    chk("abort_exp", {61'd0, exp_final}, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6'd1, 3'd2, 1'b1, 64'h12345678_00000000, mk(32'h12345680, 6'd1, 3'd2, 1'b1));

    // Randomized vectors against the model, biased toward ties and carries.
    for (int i = 0; i < 300; i++) begin
      logic [63:0] sm;
      int mode;
      sm = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      if (mode == 1) sm[31:0] = 32'd0;
      if (mode == 2) sm = ~64'd0 << $urandom_range(0, 40);
      run_model(6'($urandom), 3'($urandom), 1'($urandom), sm);
    end

    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_off.md
# round_off

Rounding stage of the posit (32-bit, es = 3) arithmetic datapath. It takes the normalized, MSB-aligned 64-bit fraction produced by the upstream shift stage and the regime, exponent and sign fields. It rounds the fraction to the number of bits a 32-bit posit can hold for that regime, using round-to-nearest, ties-to-even. It carries any rounding overflow into the exponent and regime, and delivers the result to the packing stage with a start/done handshake.

## Interface
- No parameters.
- `clk`  input  1  single system clock, rising edge.
- `rst_n`  input  1  reset; one clock, asynchronous, active-low.
- `start`  input  1  request; sampled in IDLE.
- `shifted_mantissa`  input  64  fraction bits after the hidden 1, MSB-aligned at bit 63.
- `k_out`  input  6  regime value k, two's complement, range -32..31.
- `exp_out`  input  3  exponent field, 0..7.
- `sign_out`  input  1  sign of the result.
- `mantissa_out`  output  32  rounded fraction, MSB-aligned; bits below the kept width are 0.
- `k_final`  output  6  regime after rounding carry.
- `exp_final`  output  3  exponent after rounding carry.
- `sign_final`  output  1  copy of the latched `sign_out`.
- `done`  output  1  result valid (Moore output: high in COMPLETE).

## Operation
- **State machine:** IDLE, ROUND, COMPLETE.
  - IDLE with start=1: latch all four inputs, go to ROUND.
  - ROUND: compute the result, register all outputs, go to COMPLETE.
  - COMPLETE: done=1; stay while start=1; return to IDLE when start=0.
- **Regime run length:**
  - rl = k+2 when k ≥ 0 (k_out[5]=0).
  - rl = (−k)+1 when k < 0.
- **Fraction width:** fw = 28 − rl when rl < 28, otherwise fw = 0 (32 bits minus sign, regime and 3 exponent bits).
- **Rounding fields:**
  - kept = shifted_mantissa[63 : 64−fw].
  - guard = bit 63−fw.
  - sticky = OR of all bits below the guard bit.
  - lsb = kept[0], or exp_out[0] when fw = 0.
- **Round-up condition:** guard & (sticky | lsb).
- **Round-up effect:** kept+1, computed over fw bits.
- **Fraction overflow** (kept was all ones, or fw = 0):
  - Fraction becomes 0 and exp increments.
  - If exp was 7, exp becomes 0 and k increments.
- **Saturation:** if k = 31 and exp = 7 and the carry reaches the regime, hold k_final=31, exp_final=7, mantissa 0 (no wrap).
- **Output packing:** mantissa_out = {kept, (32−fw) zeros}; when fw = 0, mantissa_out = 0.
- Sign passes through unchanged.
- Inputs are ignored outside IDLE. Outputs hold their last result until the next ROUND.

## Timing
- Reset (asynchronous, any state): state IDLE; mantissa_out, k_final, exp_final, sign_final and done all 0.
- Latency: start sampled high at edge N → outputs registered and done=1 after edge N+1 (2 cycles).
- done stays high until start is sampled low in COMPLETE; it falls one edge after that.
- If start stays high continuously, done stays high and no new operation begins. A new operation requires start low, then high again, in IDLE.
- Reset asserted mid-operation (ROUND or COMPLETE) aborts the operation: done=0 and outputs cleared immediately.
- Outputs change only on the ROUND→COMPLETE edge.

## Test plan
- k=5, exp=4, sign=0, sm=AAAAAAAA_FFFFFFFF, start held until done → mantissa_out=AAAAA800, k_final=5, exp_final=4, sign_final=0; done high 2 cycles after start.
- k=2, exp=0, sm=FFFFFFFF_FFFFFFFF → round-up overflow: mantissa_out=00000000, exp_final=1, k_final=2.
- Ties-to-even at k=0 (fw=26):
  - sm=00000020_00000000 → mantissa_out=00000000 (tie, even, no round).
  - sm=00000060_00000000 → mantissa_out=00000080.
- k=26 (fw=0), exp=3, sm=80000000_00000001 → mantissa_out=0, exp_final=4, k_final=26.
- Regime carry and saturation:
  - k=−31 (6'b100001), exp=7, sm=FFFFFFFF_00000000 → exp_final=0, k_final=−30 (6'b100010).
  - k=31, exp=7, sm all ones → k_final=31, exp_final=7, mantissa_out=0.
- Reset during ROUND, then a new request:
  - rst_n low while in ROUND → outputs 0, done 0, state IDLE.
  - Next start → normal 2-cycle result.
  - sign_out=1 passes through to sign_final=1.
